// File: rtl/core_hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard/forwarding unit:
// operand source encodings and a constant-width helper.
package core_hazard_scoreboard_pkg;

  // Operand source selected for an ID-stage read.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // Ceiling log2, never below 1 so derived vectors keep a legal width.
  function automatic int unsigned hz_clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/core_hazard_scoreboard_fwd_sel.sv
// Per-operand source resolution: matches one ID source register against the
// EX/MEM/WB producers, picks the youngest, muxes its data and flags a hazard
// the bypass network cannot cover.
module core_fwd_sel
  import core_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REGADDR_W = 5,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned FWD_EN    = 1
) (
  input  logic [REGADDR_W-1:0] rs_i,
  input  logic                 used_i,
  input  logic [XLEN-1:0]      rf_data_i,
  input  logic [CNT_W-1:0]     cnt_i,
  input  logic [REGADDR_W-1:0] ex_rd_i,
  input  logic                 ex_we_i,
  input  logic                 ex_isload_i,
  input  logic [XLEN-1:0]      ex_result_i,
  input  logic [REGADDR_W-1:0] mem_rd_i,
  input  logic                 mem_we_i,
  input  logic                 mem_isload_i,
  input  logic                 mem_load_done_i,
  input  logic [XLEN-1:0]      mem_result_i,
  input  logic [REGADDR_W-1:0] wb_rd_i,
  input  logic                 wb_we_i,
  input  logic [XLEN-1:0]      wb_data_i,
  output logic [1:0]           sel_o,
  output logic [XLEN-1:0]      opnd_o,
  output logic                 stall_o
);

  fwd_sel_e sel;
  logic     active;
  logic     ex_hit;
  logic     mem_hit;
  logic     wb_hit;
  logic     pending;

  assign active  = used_i & (rs_i != '0);
  assign ex_hit  = ex_we_i  & (ex_rd_i  == rs_i);
  assign mem_hit = mem_we_i & (mem_rd_i == rs_i);
  assign wb_hit  = wb_we_i  & (wb_rd_i  == rs_i);
  assign pending = (cnt_i != '0);

  // Youngest-first source priority and the hazard left over after bypassing.
  always_comb begin
    sel     = FWD_RF;
    stall_o = 1'b0;
    if (active) begin
      if (FWD_EN != 0) begin
        if (ex_hit) begin
          sel     = FWD_EX;
          stall_o = ex_isload_i;
        end else if (mem_hit) begin
          sel     = FWD_MEM;
          stall_o = mem_isload_i & ~mem_load_done_i;
        end else if (wb_hit) begin
          sel     = FWD_WB;
        end else begin
          stall_o = pending;
        end
      end else begin
        // Last outstanding writer committing this cycle writes through the RF.
        stall_o = pending & ~(wb_hit & (cnt_i == CNT_W'(1)));
      end
    end
  end

  // Operand data mux driven by the resolved source.
  always_comb begin
    unique case (sel)
      FWD_EX:  opnd_o = ex_result_i;
      FWD_MEM: opnd_o = mem_result_i;
      FWD_WB:  opnd_o = wb_data_i;
      default: opnd_o = rf_data_i;
    endcase
  end

  assign sel_o = sel;

endmodule

// File: rtl/core_hazard_scoreboard.sv
// ID-stage hazard/forwarding unit: per-register in-flight writer counters,
// outstanding-load counter, operand source selection and the ID stall.
module core_hazard_scoreboard
  import core_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned MAX_LOADS = 2,
  parameter int unsigned FWD_EN    = 1,
  localparam int unsigned REGADDR_W = hz_clog2(NREGS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ID_VALID,
  input  logic [REGADDR_W-1:0] ID_RS1,
  input  logic [REGADDR_W-1:0] ID_RS2,
  input  logic                 ID_RS1_USED,
  input  logic                 ID_RS2_USED,
  input  logic [REGADDR_W-1:0] ID_RD,
  input  logic                 ID_RD_WE,
  input  logic                 ID_ISLOAD,
  input  logic [XLEN-1:0]      RF_RDATA1,
  input  logic [XLEN-1:0]      RF_RDATA2,
  input  logic [REGADDR_W-1:0] EX_RD,
  input  logic                 EX_RD_WE,
  input  logic                 EX_ISLOAD,
  input  logic [XLEN-1:0]      EX_RESULT,
  input  logic [REGADDR_W-1:0] MEM_RD,
  input  logic                 MEM_RD_WE,
  input  logic                 MEM_ISLOAD,
  input  logic [XLEN-1:0]      MEM_RESULT,
  input  logic                 MEM_LOAD_DONE,
  input  logic [REGADDR_W-1:0] WB_RD,
  input  logic                 WB_WE,
  input  logic [XLEN-1:0]      WB_DATA,
  input  logic                 FLUSH_EX,
  input  logic [REGADDR_W-1:0] FLUSH_EX_RD,
  input  logic                 FLUSH_EX_RD_WE,
  input  logic                 FLUSH_EX_ISLOAD,
  output logic                 STALL_ID,
  output logic                 ISSUE,
  output logic [1:0]           FWD_SEL_RS1,
  output logic [1:0]           FWD_SEL_RS2,
  output logic [XLEN-1:0]      OPND1,
  output logic [XLEN-1:0]      OPND2,
  output logic [31:0]          STALL_CYCLES
);

  localparam int unsigned LD_W = hz_clog2(MAX_LOADS + 1);

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [LD_W-1:0]  load_cnt_q;
  logic [LD_W-1:0]  load_cnt_d;
  logic [31:0]      stall_cycles_q;
  logic [31:0]      stall_cycles_d;

  logic             stall_rs1;
  logic             stall_rs2;
  logic             stall_ld_full;
  logic             stall_sat;
  logic             cnt_uflow;
  logic             uf_r;
  logic [LD_W:0]    ld_up;
  logic [LD_W:0]    ld_dn;
  logic             ld_uflow;

  // Net counter update for one register; clamps at zero and reports underflow.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur,
                                                input logic inc,
                                                input logic dec_a,
                                                input logic dec_b,
                                                output logic uflow);
    logic [CNT_W:0] up;
    logic [CNT_W:0] dn;
    up    = {1'b0, cur} + (CNT_W+1)'(inc);
    dn    = (CNT_W+1)'(dec_a) + (CNT_W+1)'(dec_b);
    uflow = (up < dn);
    return uflow ? '0 : CNT_W'(up - dn);
  endfunction

  core_fwd_sel #(
    .XLEN(XLEN), .REGADDR_W(REGADDR_W), .CNT_W(CNT_W), .FWD_EN(FWD_EN)
  ) u_fwd_rs1 (
    .rs_i(ID_RS1), .used_i(ID_RS1_USED), .rf_data_i(RF_RDATA1), .cnt_i(cnt_q[ID_RS1]),
    .ex_rd_i(EX_RD), .ex_we_i(EX_RD_WE), .ex_isload_i(EX_ISLOAD), .ex_result_i(EX_RESULT),
    .mem_rd_i(MEM_RD), .mem_we_i(MEM_RD_WE), .mem_isload_i(MEM_ISLOAD),
    .mem_load_done_i(MEM_LOAD_DONE), .mem_result_i(MEM_RESULT),
    .wb_rd_i(WB_RD), .wb_we_i(WB_WE), .wb_data_i(WB_DATA),
    .sel_o(FWD_SEL_RS1), .opnd_o(OPND1), .stall_o(stall_rs1)
  );

  core_fwd_sel #(
    .XLEN(XLEN), .REGADDR_W(REGADDR_W), .CNT_W(CNT_W), .FWD_EN(FWD_EN)
  ) u_fwd_rs2 (
    .rs_i(ID_RS2), .used_i(ID_RS2_USED), .rf_data_i(RF_RDATA2), .cnt_i(cnt_q[ID_RS2]),
    .ex_rd_i(EX_RD), .ex_we_i(EX_RD_WE), .ex_isload_i(EX_ISLOAD), .ex_result_i(EX_RESULT),
    .mem_rd_i(MEM_RD), .mem_we_i(MEM_RD_WE), .mem_isload_i(MEM_ISLOAD),
    .mem_load_done_i(MEM_LOAD_DONE), .mem_result_i(MEM_RESULT),
    .wb_rd_i(WB_RD), .wb_we_i(WB_WE), .wb_data_i(WB_DATA),
    .sel_o(FWD_SEL_RS2), .opnd_o(OPND2), .stall_o(stall_rs2)
  );

  assign stall_ld_full = ID_ISLOAD & (load_cnt_q == LD_W'(MAX_LOADS));
  assign stall_sat     = ID_RD_WE & (ID_RD != '0) & (cnt_q[ID_RD] == '1);
  assign STALL_ID      = ID_VALID & (stall_rs1 | stall_rs2 | stall_ld_full | stall_sat);
  assign ISSUE         = ID_VALID & ~STALL_ID;
  assign STALL_CYCLES  = stall_cycles_q;

  // Per-register writer counters; x0 is never tracked.
  always_comb begin
    cnt_uflow = 1'b0;
    uf_r      = 1'b0;
    cnt_d[0]  = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      cnt_d[r] = cnt_step(cnt_q[r],
                          ISSUE & ID_RD_WE & (ID_RD == REGADDR_W'(r)),
                          WB_WE & (WB_RD == REGADDR_W'(r)),
                          FLUSH_EX & FLUSH_EX_RD_WE & (FLUSH_EX_RD == REGADDR_W'(r)),
                          uf_r);
      cnt_uflow = cnt_uflow | uf_r;
    end
  end

  // Outstanding-load counter and saturating stall-cycle counter.
  always_comb begin
    ld_up          = {1'b0, load_cnt_q} + (LD_W+1)'(ISSUE & ID_ISLOAD);
    ld_dn          = (LD_W+1)'(MEM_LOAD_DONE) + (LD_W+1)'(FLUSH_EX & FLUSH_EX_ISLOAD);
    ld_uflow       = (ld_up < ld_dn);
    load_cnt_d     = ld_uflow ? '0 : LD_W'(ld_up - ld_dn);
    stall_cycles_d = stall_cycles_q;
    if (STALL_ID && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      load_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      cnt_q          <= cnt_d;
      load_cnt_q     <= load_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  a_cnt_no_underflow:  assert property (@(posedge CLK) disable iff (RST) !cnt_uflow);
  a_load_no_underflow: assert property (@(posedge CLK) disable iff (RST) !ld_uflow);

endmodule

// File: tb/tb_core_hazard_scoreboard.sv
// Bench for core_hazard_scoreboard: a forwarding instance and a stall-only
// instance share stimulus; each has its own reset and ID_VALID so only the
// instance under test sees traffic. Expected outputs are queued as stimulus
// is applied and popped when the outputs are sampled on the falling edge.
module tb_core_hazard_scoreboard;

  localparam logic [31:0] RF1 = 32'hAAAA_0001;
  localparam logic [31:0] RF2 = 32'hBBBB_0002;

  typedef struct packed {
    logic        stall;
    logic        issue;
    logic [1:0]  sel1;
    logic [1:0]  sel2;
    logic [31:0] op1;
    logic [31:0] op2;
  } obs_t;

  typedef struct {
    string tag;
    bit    inst;
    obs_t  v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_all, sel_b, id_valid;
  logic rst_a, rst_b, valid_a, valid_b;
  logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd, fl_rd;
  logic        id_u1, id_u2, id_we, id_ld;
  logic [31:0] rf1, rf2, ex_res, mem_res, wb_data;
  logic        ex_we, ex_ld, mem_we, mem_ld, mem_done, wb_we, fl, fl_we, fl_ld;

  logic        stall_a, issue_a, stall_b, issue_b;
  logic [1:0]  sel1_a, sel2_a, sel1_b, sel2_b;
  logic [31:0] op1_a, op2_a, op1_b, op2_b, cyc_a, cyc_b;

  assign rst_a   = rst_all | sel_b;
  assign rst_b   = rst_all | ~sel_b;
  assign valid_a = id_valid & ~sel_b;
  assign valid_b = id_valid & sel_b;

  core_hazard_scoreboard #(.XLEN(32), .NREGS(32), .CNT_W(2), .MAX_LOADS(2), .FWD_EN(1)) u_dut_fwd (
    .CLK(clk), .RST(rst_a), .ID_VALID(valid_a),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_RS1_USED(id_u1), .ID_RS2_USED(id_u2),
    .ID_RD(id_rd), .ID_RD_WE(id_we), .ID_ISLOAD(id_ld), .RF_RDATA1(rf1), .RF_RDATA2(rf2),
    .EX_RD(ex_rd), .EX_RD_WE(ex_we), .EX_ISLOAD(ex_ld), .EX_RESULT(ex_res),
    .MEM_RD(mem_rd), .MEM_RD_WE(mem_we), .MEM_ISLOAD(mem_ld), .MEM_RESULT(mem_res),
    .MEM_LOAD_DONE(mem_done), .WB_RD(wb_rd), .WB_WE(wb_we), .WB_DATA(wb_data),
    .FLUSH_EX(fl), .FLUSH_EX_RD(fl_rd), .FLUSH_EX_RD_WE(fl_we), .FLUSH_EX_ISLOAD(fl_ld),
    .STALL_ID(stall_a), .ISSUE(issue_a), .FWD_SEL_RS1(sel1_a), .FWD_SEL_RS2(sel2_a),
    .OPND1(op1_a), .OPND2(op2_a), .STALL_CYCLES(cyc_a)
  );

  core_hazard_scoreboard #(.XLEN(32), .NREGS(32), .CNT_W(2), .MAX_LOADS(2), .FWD_EN(0)) u_dut_stall (
    .CLK(clk), .RST(rst_b), .ID_VALID(valid_b),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_RS1_USED(id_u1), .ID_RS2_USED(id_u2),
    .ID_RD(id_rd), .ID_RD_WE(id_we), .ID_ISLOAD(id_ld), .RF_RDATA1(rf1), .RF_RDATA2(rf2),
    .EX_RD(ex_rd), .EX_RD_WE(ex_we), .EX_ISLOAD(ex_ld), .EX_RESULT(ex_res),
    .MEM_RD(mem_rd), .MEM_RD_WE(mem_we), .MEM_ISLOAD(mem_ld), .MEM_RESULT(mem_res),
    .MEM_LOAD_DONE(mem_done), .WB_RD(wb_rd), .WB_WE(wb_we), .WB_DATA(wb_data),
    .FLUSH_EX(fl), .FLUSH_EX_RD(fl_rd), .FLUSH_EX_RD_WE(fl_we), .FLUSH_EX_ISLOAD(fl_ld),
    .STALL_ID(stall_b), .ISSUE(issue_b), .FWD_SEL_RS1(sel1_b), .FWD_SEL_RS2(sel2_b),
    .OPND1(op1_b), .OPND2(op2_b), .STALL_CYCLES(cyc_b)
  );

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_u1 = 0; id_u2 = 0; id_rd = 0; id_we = 0; id_ld = 0;
    rf1 = RF1; rf2 = RF2;
    ex_rd = 0; ex_we = 0; ex_ld = 0; ex_res = 0;
    mem_rd = 0; mem_we = 0; mem_ld = 0; mem_res = 0; mem_done = 0;
    wb_rd = 0; wb_we = 0; wb_data = 0;
    fl = 0; fl_rd = 0; fl_we = 0; fl_ld = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    id_valid = v; id_rs1 = r1; id_u1 = u1; id_rs2 = r2; id_u2 = u2; id_rd = rd; id_we = we; id_ld = ld;
  endtask

  task automatic set_ex(input logic [4:0] rd, input logic we, input logic ld, input logic [31:0] res);
    ex_rd = rd; ex_we = we; ex_ld = ld; ex_res = res;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic we, input logic ld, input logic [31:0] res,
                         input logic done);
    mem_rd = rd; mem_we = we; mem_ld = ld; mem_res = res; mem_done = done;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic we, input logic [31:0] d);
    wb_rd = rd; wb_we = we; wb_data = d;
  endtask

  task automatic set_flush(input logic f, input logic [4:0] rd, input logic we, input logic ld);
    fl = f; fl_rd = rd; fl_we = we; fl_ld = ld;
  endtask

  function automatic obs_t mk(input logic s, input logic i, input logic [1:0] s1, input logic [1:0] s2,
                              input logic [31:0] o1, input logic [31:0] o2);
    obs_t r;
    r.stall = s; r.issue = i; r.sel1 = s1; r.sel2 = s2; r.op1 = o1; r.op2 = o2;
    return r;
  endfunction

  task automatic push(input string tag, input bit inst, input obs_t v);
    exp_t e;
    e.tag = tag; e.inst = inst; e.v = v;
    sb.push_back(e);
  endtask

  function automatic obs_t observe(input bit inst);
    if (inst) return mk(stall_b, issue_b, sel1_b, sel2_b, op1_b, op2_b);
    return mk(stall_a, issue_a, sel1_a, sel2_a, op1_a, op2_a);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit b);
    sel_b = b; idle(); rst_all = 1'b1;
    step(); step();
    rst_all = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    exp_t e; obs_t o;
    do_reset(0);
    push("reset_outputs", 0, mk(0, 0, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    checks++;
    if (cyc_a !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0d expected 0", cyc_a); end
    step();
    set_id(0, 7, 1, 0, 0, 0, 0, 0); set_ex(7, 1, 1, 32'h77);
    @(negedge clk); checks++;
    if ({stall_a, issue_a} !== 2'b00) begin
      errors++; $display("FAIL invalid_no_stall: got %b expected 00", {stall_a, issue_a});
    end
    step();
  endtask

  task automatic test_ex_forward();
    exp_t e; obs_t o;
    do_reset(0);
    set_id(1, 1, 1, 2, 1, 5, 1, 0);
    push("fwd_issue_add_x5", 0, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_id(1, 5, 1, 1, 1, 6, 1, 0); set_ex(5, 1, 0, 32'h10);
    push("fwd_from_ex", 0, mk(0, 1, 2'd1, 2'd0, 32'h10, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_id(1, 5, 1, 6, 1, 0, 0, 0); set_ex(6, 1, 0, 32'h60);
    set_mem(5, 1, 0, 32'h50, 0); set_wb(5, 1, 32'h5B);
    push("fwd_mem_over_wb", 0, mk(0, 1, 2'd2, 2'd1, 32'h50, 32'h60));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_id(1, 6, 1, 5, 1, 0, 0, 0); set_ex(9, 1, 0, 32'h90);
    set_mem(0, 0, 0, 0, 0); set_wb(6, 1, 32'h6B);
    push("fwd_from_wb", 0, mk(0, 1, 2'd3, 2'd0, 32'h6B, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
  endtask

  task automatic test_x0();
    exp_t e; obs_t o;
    do_reset(0);
    set_id(1, 0, 0, 0, 0, 0, 1, 0);
    push("x0_write_issue", 0, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_id(1, 0, 1, 0, 1, 0, 1, 0); set_ex(0, 1, 1, 32'hDEAD);
    set_mem(0, 1, 1, 32'hBEEF, 0); set_wb(0, 1, 32'h0B);
    push("x0_read_rf", 0, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
  endtask

  task automatic test_load_use();
    exp_t e; obs_t o;
    do_reset(0);
    set_id(1, 1, 1, 0, 0, 7, 1, 1);
    push("lu_issue_lw_x7", 0, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_id(1, 7, 1, 2, 1, 8, 1, 0); set_ex(7, 1, 1, 32'h1234);
    push("lu_stall_ex_load", 0, mk(1, 0, 2'd1, 2'd0, 32'h1234, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    checks++;
    if (cyc_a !== 32'd0) begin errors++; $display("FAIL lu_cycles_before: got %0d expected 0", cyc_a); end
    step();
    set_ex(0, 0, 0, 0); set_mem(7, 1, 1, 32'hCAFE, 1);
    push("lu_fwd_mem_done", 0, mk(0, 1, 2'd2, 2'd0, 32'hCAFE, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    checks++;
    if (cyc_a !== 32'd1) begin errors++; $display("FAIL lu_cycles_one: got %0d expected 1", cyc_a); end
    step();
    set_id(1, 7, 1, 2, 1, 0, 0, 0); set_mem(7, 1, 1, 32'hCAFE, 0);
    push("lu_stall_mem_not_done", 0, mk(1, 0, 2'd2, 2'd0, 32'hCAFE, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    idle();
    push("lu_idle", 0, mk(0, 0, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    checks++;
    if (cyc_a !== 32'd2) begin errors++; $display("FAIL lu_cycles_two: got %0d expected 2", cyc_a); end
    step();
  endtask

  task automatic test_stall_only();
    exp_t e; obs_t o;
    do_reset(1);
    set_id(1, 0, 0, 0, 0, 3, 1, 0);
    push("so_issue_x3", 1, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_id(1, 3, 1, 0, 0, 4, 1, 0); set_ex(3, 1, 0, 32'h33);
    push("so_stall_ex", 1, mk(1, 0, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_ex(0, 0, 0, 0); set_mem(3, 1, 0, 32'h33, 0);
    push("so_stall_mem", 1, mk(1, 0, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_mem(0, 0, 0, 0, 0); set_wb(3, 1, 32'h33);
    push("so_wb_writethrough", 1, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_wb(0, 0, 0); set_id(1, 0, 0, 0, 0, 4, 1, 0);
    push("so_second_x4", 1, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    checks++;
    if (cyc_b !== 32'd2) begin errors++; $display("FAIL so_cycles_two: got %0d expected 2", cyc_b); end
    step();
    set_id(1, 4, 1, 0, 0, 0, 0, 0); set_wb(4, 1, 32'h44);
    push("so_wb_cnt2_stall", 1, mk(1, 0, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    push("so_wb_cnt1_issue", 1, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    idle();
    push("so_idle", 1, mk(0, 0, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    checks++;
    if (cyc_b !== 32'd3) begin errors++; $display("FAIL so_cycles_three: got %0d expected 3", cyc_b); end
    step();
  endtask

  task automatic test_flush();
    exp_t e; obs_t o;
    do_reset(0);
    set_id(1, 0, 0, 0, 0, 9, 1, 0);
    push("fl_issue_x9", 0, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_flush(1, 9, 1, 0);
    push("fl_issue_with_flush", 0, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_flush(0, 0, 0, 0); set_id(1, 9, 1, 0, 0, 0, 0, 0);
    push("fl_pending_stall", 0, mk(1, 0, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_wb(9, 1, 32'h99);
    push("fl_wb_forward", 0, mk(0, 1, 2'd3, 2'd0, 32'h99, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_wb(0, 0, 0);
    push("fl_count_cleared", 0, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
  endtask

  task automatic test_saturation();
    exp_t e; obs_t o;
    do_reset(0);
    set_id(1, 0, 0, 0, 0, 10, 1, 0);
    for (int i = 0; i < 3; i++) begin
      push($sformatf("sat_issue_%0d", i), 0, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
      @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
      step();
    end
    push("sat_full_stall", 0, mk(1, 0, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_wb(10, 1, 32'hA);
    push("sat_wb_same_cycle", 0, mk(1, 0, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_wb(0, 0, 0);
    push("sat_released", 0, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
  endtask

  task automatic test_max_loads();
    exp_t e; obs_t o;
    do_reset(0);
    for (int i = 0; i < 2; i++) begin
      set_id(1, 0, 0, 0, 0, 5'(11 + i), 1, 1);
      push($sformatf("ml_load_%0d", i), 0, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
      @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
      step();
    end
    set_id(1, 0, 0, 0, 0, 13, 1, 1);
    push("ml_third_stall", 0, mk(1, 0, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_mem(0, 0, 0, 0, 1);
    push("ml_done_same_cycle", 0, mk(1, 0, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
    set_mem(0, 0, 0, 0, 0);
    push("ml_third_issues", 0, mk(0, 1, 2'd0, 2'd0, RF1, RF2));
    @(negedge clk); e = sb.pop_front(); o = observe(e.inst); checks++;
    if (o !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, o, e.v); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel_b = 1'b0; rst_all = 1'b1; idle();
    test_reset();
    test_ex_forward();
    test_x0();
    test_load_use();
    test_stall_only();
    test_flush();
    test_saturation();
    test_max_loads();
    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
